// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART byte width and byte type
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-to-FIFO capture and FIFO-to-host stream signals
interface uart_rx_fifo_if;
    import uart_pkg::*;

    uart_byte_t rx_data;
    logic       rx_done;
    uart_byte_t m_data;
    logic       m_valid;
    logic       m_ready;

    // Master drives received bytes in and consumes the stream; slave is the FIFO.
    modport master (
        output rx_data,
        output rx_done,
        output m_ready,
        input  m_data,
        input  m_valid
    );

    modport slave (
        input  rx_data,
        input  rx_done,
        input  m_ready,
        output m_data,
        output m_valid
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x byte storage, synchronous write, asynchronous read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  uart_byte_t        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output uart_byte_t        rdata_o
);

    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive byte FIFO with show-ahead stream output and sticky overrun
// Optional registered almost_full output enabled by UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH    = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , parameter int AF_LEVEL = DEPTH - 2
`endif
    , localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_fifo_if.slave     bus,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overrun,
    input  logic              clr_overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , output logic            almost_full
`endif
);

    localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            done_q;
    logic            overrun_q, overrun_d;
    logic            wr_req;
    logic            rd_fire;
    logic            wr_en;
    uart_byte_t      head_data;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign bus.m_valid = !empty;
    assign bus.m_data  = head_data;
    assign overrun     = overrun_q;

    always_comb begin
        wr_req    = bus.rx_done && !done_q;
        rd_fire   = !empty && bus.m_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en     = wr_req && (!full || rd_fire);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = overrun_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end
        if (wr_req && full && !rd_fire) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            done_q    <= bus.rx_done;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (bus.rx_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (head_data)
    );

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_THRESH = AF_LEVEL[ADDR_W:0];

    logic almost_full_q;
    logic almost_full_d;

    assign almost_full_d = (count >= AF_THRESH);
    assign almost_full   = almost_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_overrun;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overrun;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic              almost_full;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    uart_rx_fifo_if bus();

    uart_rx_fifo #(
        .DEPTH (DEPTH)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        , .AF_LEVEL (14)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        , .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input uart_byte_t b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.m_ready = 1'b0; clr_overrun = 1'b0;
        step(); step();
        rst = 1'b0;
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", full); end
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        tests_run++; if (count !== 5'd0 || bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_read: got count %0d m_valid %b expected 0 0", count, bus.m_valid); end
    endtask

    task automatic test_held_done();
        bus.rx_data = 8'h41;
        bus.rx_done = 1'b1;
        tests_run++; if (bus.m_valid !== 1'b0) begin tests_failed++; $display("FAIL held_pre_edge_valid: got %b expected 0", bus.m_valid); end
        step();
        tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL held_count_first: got %0d expected 1", count); end
        tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h41) begin tests_failed++; $display("FAIL held_head: got valid %b data %h expected 1 41", bus.m_valid, bus.m_data); end
        for (int i = 0; i < 4; i++) step();
        bus.rx_done = 1'b0;
        step();
        tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL held_count_single: got %0d expected 1", count); end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL held_drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fill_drain();
        uart_byte_t exp;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        tests_run++; if (full !== 1'b1 || count !== 5'd16) begin tests_failed++; $display("FAIL fill_full: got full %b count %0d expected 1 16", full, count); end
        tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("FAIL fill_empty: got %b expected 0", empty); end
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = 8'(8'h10 + i);
            tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin tests_failed++; $display("FAIL drain_order[%0d]: got valid %b data %h expected 1 %h", i, bus.m_valid, bus.m_data, exp); end
            step();
        end
        bus.m_ready = 1'b0;
        tests_run++; if (empty !== 1'b1 || count !== 5'd0) begin tests_failed++; $display("FAIL drain_empty: got empty %b count %0d expected 1 0", empty, count); end
    endtask

    task automatic test_overrun();
        uart_byte_t exp;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i));
        push(8'hAA);
        tests_run++; if (overrun !== 1'b1 || count !== 5'd16) begin tests_failed++; $display("FAIL overrun_set: got overrun %b count %0d expected 1 16", overrun, count); end
        bus.rx_data = 8'hBB; bus.rx_done = 1'b1; clr_overrun = 1'b1;
        step();
        bus.rx_done = 1'b0; clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_set_wins: got %b expected 1", overrun); end
        step();
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = 8'(8'h20 + i);
            tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin tests_failed++; $display("FAIL overrun_drain[%0d]: got valid %b data %h expected 1 %h", i, bus.m_valid, bus.m_data, exp); end
            step();
        end
        bus.m_ready = 1'b0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL overrun_no_extra: got empty %b head %h expected empty 1", empty, bus.m_data); end
    endtask

    task automatic test_full_simul();
        uart_byte_t exp;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i));
        bus.rx_data = 8'h55; bus.rx_done = 1'b1; bus.m_ready = 1'b1;
        step();
        bus.rx_done = 1'b0; bus.m_ready = 1'b0;
        tests_run++; if (count !== 5'd16 || full !== 1'b1) begin tests_failed++; $display("FAIL simul_count: got count %0d full %b expected 16 1", count, full); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
        tests_run++; if (bus.m_data !== 8'h31) begin tests_failed++; $display("FAIL simul_head: got %h expected 31", bus.m_data); end
        step();
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i < DEPTH - 1) ? 8'(8'h31 + i) : 8'h55;
            tests_run++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp) begin tests_failed++; $display("FAIL simul_drain[%0d]: got valid %b data %h expected 1 %h", i, bus.m_valid, bus.m_data, exp); end
            step();
        end
        bus.m_ready = 1'b0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL simul_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap_and_reset();
        uart_byte_t q[$];
        uart_byte_t b;
        logic       rd;
        for (int i = 0; i < 34; i++) begin
            b  = 8'(8'h80 + i);
            rd = (i % 3 != 0);
            bus.rx_data = b; bus.rx_done = 1'b1; bus.m_ready = rd;
            tests_run++; if (count !== 5'(q.size())) begin tests_failed++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, q.size()); end
            tests_run++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin tests_failed++; $display("FAIL wrap_flags[%0d]: got empty %b full %b expected %b %b", i, empty, full, q.size() == 0, q.size() == DEPTH); end
            if (q.size() > 0) begin
                tests_run++; if (bus.m_data !== q[0]) begin tests_failed++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, bus.m_data, q[0]); end
            end
            step();
            if (rd && q.size() > 0) void'(q.pop_front());
            q.push_back(b);
            bus.rx_done = 1'b0; bus.m_ready = 1'b0;
            step();
        end
        tests_run++; if (count !== 5'(q.size()) || q.size() == 0) begin tests_failed++; $display("FAIL wrap_final_count: got %0d expected %0d", count, q.size()); end
        rst = 1'b1;
        #1;
        tests_run++; if (count !== 5'd0 || bus.m_valid !== 1'b0 || overrun !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL async_reset: got count %0d valid %b overrun %b empty %b expected 0 0 0 1", count, bus.m_valid, overrun, empty); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_done_high_at_reset();
        rst = 1'b1; bus.rx_data = 8'h77; bus.rx_done = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL rst_done_pre: got %0d expected 0", count); end
        step();
        tests_run++; if (count !== 5'd1 || bus.m_data !== 8'h77) begin tests_failed++; $display("FAIL rst_done_write: got count %0d data %h expected 1 77", count, bus.m_data); end
        step(); step();
        tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL rst_done_once: got %0d expected 1", count); end
        bus.rx_done = 1'b0; bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL rst_done_drain: got %b expected 1", empty); end
    endtask

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL af_reset: got %b expected 0", almost_full); end
        for (int i = 0; i < 13; i++) push(8'(8'hC0 + i));
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL af_at_13: got %b expected 0", almost_full); end
        bus.rx_data = 8'hCD; bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        tests_run++; if (almost_full !== 1'b0 || count !== 5'd14) begin tests_failed++; $display("FAIL af_same_cycle: got af %b count %0d expected 0 14", almost_full, count); end
        step();
        tests_run++; if (almost_full !== 1'b1) begin tests_failed++; $display("FAIL af_set: got %b expected 1", almost_full); end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        step();
        tests_run++; if (almost_full !== 1'b0 || count !== 5'd13) begin tests_failed++; $display("FAIL af_clear: got af %b count %0d expected 0 13", almost_full, count); end
    endtask
`endif

    initial begin
        test_reset();
        test_held_done();
        test_fill_drain();
        test_overrun();
        test_full_simul();
        test_wrap_and_reset();
        test_done_high_at_reset();
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
